// File: rtl/serial_adder_if.sv
// Operand/result bundle between the operand input logic and the bit-serial adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic             i_sub;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_c;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_overflow;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_start, i_sub, i_a, i_b, i_c,
        input  o_sum, o_carry, o_overflow, o_busy, o_done
    );

    modport slave (
        input  i_start, i_sub, i_a, i_b, i_c,
        output o_sum, o_carry, o_overflow, o_busy, o_done
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per op.
// Results load together on the final bit and are flagged by a one-cycle done strobe.
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic           i_clk,
    input logic           i_reset,
    serial_adder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_cy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_cout;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum_next;

    function automatic logic f_maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_cy;
    assign w_cout     = f_maj(r_a_sh[0], r_b_sh[0], r_cy);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept   = bus.i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_cy     <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        // Subtraction is a + ~b + ~borrow, so invert B and the carry-in once here.
                        r_a_sh  <= bus.i_a;
                        r_b_sh  <= bus.i_sub ? ~bus.i_b : bus.i_b;
                        r_cy    <= bus.i_c ^ bus.i_sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ADD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ADD: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_sum_sh <= w_sum_next;
                    r_cy     <= w_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // r_cy is the carry into the MSB on this last bit.
                        r_sum   <= w_sum_next;
                        r_carry <= w_cout;
                        r_ovf   <= r_cy ^ w_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_sum      = r_sum;
    assign bus.o_carry    = r_carry;
    assign bus.o_overflow = r_ovf;
    assign bus.o_busy     = r_busy;
    assign bus.o_done     = r_done;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and exhaustive checks of serial_adder at WIDTH=8 and WIDTH=4.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8)) dut8 (.i_clk(clk), .i_reset(rst), .bus(bus8));
    serial_adder #(.WIDTH(4)) dut4 (.i_clk(clk), .i_reset(rst), .bus(bus4));

    typedef struct {
        string      name;
        bit         sub;
        logic [7:0] a;
        logic [7:0] b;
        bit         c;
        logic [7:0] sum;
        bit         carry;
        bit         ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Waits up to 40 cycles for o_done, counting edges since the accept edge.
    task automatic wait_done8(output int lat);
        lat = 0;
        while (!bus8.o_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op8(input bit sub, input logic [7:0] a, input logic [7:0] b, input bit c,
                       output int lat, output bit busy0, output bit done_next);
        @(negedge clk);
        bus8.i_start = 1'b1;
        bus8.i_sub   = sub;
        bus8.i_a     = a;
        bus8.i_b     = b;
        bus8.i_c     = c;
        @(negedge clk);
        bus8.i_start = 1'b0;
        bus8.i_a     = 8'($urandom);
        bus8.i_b     = 8'($urandom);
        bus8.i_c     = 1'($urandom);
        busy0 = bus8.o_busy;
        wait_done8(lat);
        @(negedge clk);
        done_next = bus8.o_done;
    endtask

    task automatic op4(input bit sub, input logic [3:0] a, input logic [3:0] b, input bit c,
                       output logic [5:0] res);
        int n;
        @(negedge clk);
        bus4.i_start = 1'b1;
        bus4.i_sub   = sub;
        bus4.i_a     = a;
        bus4.i_b     = b;
        bus4.i_c     = c;
        @(negedge clk);
        bus4.i_start = 1'b0;
        n = 0;
        while (!bus4.o_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n != 4) res = 6'h3f ^ {bus4.o_overflow, bus4.o_carry, bus4.o_sum};
        else        res = {bus4.o_overflow, bus4.o_carry, bus4.o_sum};
    endtask

    function automatic logic [5:0] ref4(input bit sub, input int a, input int b, input int c);
        int full, sa, sb, sfull;
        bit carry, ovf;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        if (!sub) begin
            full  = a + b + c;
            carry = (full >= 16);
            sfull = sa + sb + c;
        end else begin
            full  = a - b - c;
            carry = (full >= 0);
            sfull = sa - sb - c;
        end
        ovf = (sfull > 7) || (sfull < -8);
        return {ovf, carry, 4'(full & 15)};
    endfunction

    initial begin
        int         lat, lat2, seen;
        bit         busy0, dn;
        logic [5:0] got4;

        vecs[0] = '{"add_5A_3C", 1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{"add_FF_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"add_00_00_c", 1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{"sub_10_20", 1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{"sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};

        bus8.i_start = 1'b0; bus8.i_sub = 1'b0; bus8.i_a = '0; bus8.i_b = '0; bus8.i_c = 1'b0;
        bus4.i_start = 1'b0; bus4.i_sub = 1'b0; bus4.i_a = '0; bus4.i_b = '0; bus4.i_c = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_outputs", {bus8.o_sum, bus8.o_carry, bus8.o_overflow, bus8.o_busy, bus8.o_done}, '0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            op8(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].c, lat, busy0, dn);
            check({vecs[i].name, "_sum"}, bus8.o_sum, vecs[i].sum);
            check({vecs[i].name, "_carry"}, bus8.o_carry, vecs[i].carry);
            check({vecs[i].name, "_ovf"}, bus8.o_overflow, vecs[i].ovf);
            check({vecs[i].name, "_latency"}, lat, 8);
            check({vecs[i].name, "_busy_at_accept"}, busy0, 1'b1);
            check({vecs[i].name, "_done_width"}, dn, 1'b0);
        end

        // Start pulse in the middle of ADD must be ignored.
        @(negedge clk);
        bus8.i_start = 1'b1; bus8.i_sub = 1'b0; bus8.i_a = 8'h5A; bus8.i_b = 8'h3C; bus8.i_c = 1'b0;
        @(negedge clk);
        bus8.i_start = 1'b0;
        repeat (2) @(negedge clk);
        bus8.i_start = 1'b1; bus8.i_a = 8'hFF; bus8.i_b = 8'hFF; bus8.i_c = 1'b1; bus8.i_sub = 1'b1;
        @(negedge clk);
        bus8.i_start = 1'b0;
        lat = 3;
        while (!bus8.o_done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("midadd_latency", lat, 8);
        check("midadd_sum", {bus8.o_overflow, bus8.o_carry, bus8.o_sum}, {1'b1, 1'b0, 8'h96});
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.o_done) seen++;
        end
        check("midadd_no_queued_op", seen, 0);

        // Start held through DONE: second operation begins with no idle cycle.
        @(negedge clk);
        bus8.i_start = 1'b1; bus8.i_sub = 1'b0; bus8.i_a = 8'h12; bus8.i_b = 8'h34; bus8.i_c = 1'b0;
        @(negedge clk);
        bus8.i_a = 8'h50; bus8.i_b = 8'h30; bus8.i_sub = 1'b1; bus8.i_c = 1'b1;
        wait_done8(lat);
        check("b2b_first_latency", lat, 8);
        check("b2b_first_sum", {bus8.o_overflow, bus8.o_carry, bus8.o_sum}, {1'b0, 1'b0, 8'h46});
        @(negedge clk);
        bus8.i_start = 1'b0;
        check("b2b_handover", {bus8.o_done, bus8.o_busy}, 2'b01);
        wait_done8(lat2);
        check("b2b_second_latency", lat2, 8);
        check("b2b_second_sum", {bus8.o_overflow, bus8.o_carry, bus8.o_sum}, {1'b0, 1'b1, 8'h1F});

        // Reset at cycle 4 of ADD discards the operation.
        @(negedge clk);
        bus8.i_start = 1'b1; bus8.i_sub = 1'b0; bus8.i_a = 8'h77; bus8.i_b = 8'h11; bus8.i_c = 1'b0;
        @(negedge clk);
        bus8.i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", bus8.o_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {bus8.o_sum, bus8.o_carry, bus8.o_overflow, bus8.o_busy, bus8.o_done}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.o_done) seen++;
        end
        check("reset_no_done", seen, 0);
        op8(1'b0, 8'h77, 8'h11, 1'b0, lat, busy0, dn);
        check("post_reset_result", {bus8.o_overflow, bus8.o_carry, bus8.o_sum}, {1'b1, 1'b0, 8'h88});
        check("post_reset_latency", lat, 8);

        // WIDTH=4 exhaustive against the arithmetic model.
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    for (int c = 0; c < 2; c++) begin
                        op4(1'(s), 4'(a), 4'(b), 1'(c), got4);
                        checks++;
                        if (got4 !== ref4(1'(s), a, b, c)) begin
                            errors++;
                            $display("FAIL w4 sub=%0d a=%0h b=%0h c=%0d: got {ovf,carry,sum}=%0h, expected %0h",
                                     s, a, b, c, got4, ref4(1'(s), a, b, c));
                        end
                    end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
